// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for forwarding/hazard control
package hazard_pkg;

    localparam int TNEW_W      = 2;
    localparam int REG_AW      = 5;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [TNEW_W-1:0] tnew;
    } stage_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - per-read-port producer match, bypass select and stall decision
module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = 32,
    parameter int TW = TNEW_W
) (
    input  logic [AW-1:0] e_dst,
    input  logic [TW-1:0] e_tnew,
    input  logic [AW-1:0] m_dst,
    input  logic [TW-1:0] m_tnew,
    input  logic [AW-1:0] w_dst,
    input  logic [TW-1:0] w_tnew,
    input  logic [AW-1:0] addr,
    input  logic [TW-1:0] tuse,
    input  logic          rd_en,
    input  logic [DW-1:0] rf_data,
    input  logic [DW-1:0] e_data,
    input  logic [DW-1:0] m_data,
    input  logic [DW-1:0] w_data,
    output logic          port_stall,
    output logic [1:0]    sel,
    output logic [DW-1:0] data
);

    logic active;
    logic match_e;
    logic match_m;
    logic match_w;

    // $0 never matches a producer; disabled ports never stall
    assign active  = (addr != '0) && rd_en;
    assign match_e = active && (e_dst == addr);
    assign match_m = active && (m_dst == addr);
    assign match_w = active && (w_dst == addr);

    // Youngest matching producer decides: forward if ready, stall if too late, else wait
    always_comb begin
        port_stall = 1'b0;
        sel        = SEL_RF;
        data       = (addr == '0) ? '0 : rf_data;
        if (match_e) begin
            if (e_tnew == '0) begin
                sel  = SEL_E;
                data = e_data;
            end else if (e_tnew > tuse) begin
                port_stall = 1'b1;
            end
        end else if (match_m) begin
            if (m_tnew == '0) begin
                sel  = SEL_M;
                data = m_data;
            end else if (m_tnew > tuse) begin
                port_stall = 1'b1;
            end
        end else if (match_w) begin
            if (w_tnew == '0) begin
                sel  = SEL_W;
                data = w_data;
            end else if (w_tnew > tuse) begin
                port_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding, load-use stall and MDU interlock for the 5-stage pipeline
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREAD   = 2,
    parameter int AW      = REG_AW,
    parameter int DW      = 32,
    parameter int TW      = TNEW_W,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [AW-1:0]       d_dst,
    input  logic [TW-1:0]       d_tnew,
    input  logic [NREAD*AW-1:0] d_rd_addr,
    input  logic [NREAD*TW-1:0] d_tuse,
    input  logic [NREAD-1:0]    d_rd_en,
    input  logic [NREAD*DW-1:0] d_rf_data,
    input  logic                d_mdu_start,
    input  logic                d_mdu_is_div,
    input  logic                d_uses_mdu,
    input  logic [DW-1:0]       e_data,
    input  logic [DW-1:0]       m_data,
    input  logic [DW-1:0]       w_data,
    output logic                stall,
    output logic [NREAD*2-1:0]  fwd_sel,
    output logic [NREAD*DW-1:0] fwd_data,
    output logic                mdu_busy
);

    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);

    logic [AW-1:0]    e_dst, m_dst, w_dst;
    logic [TW-1:0]    e_tnew, m_tnew, w_tnew;
    logic             e_mdu;
    logic             e_mdu_div;
    logic [CW-1:0]    mdu_cnt;
    logic [NREAD-1:0] port_stall;

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        fwd_port_sel #(
            .AW (AW),
            .DW (DW),
            .TW (TW)
        ) u_port (
            .e_dst      (e_dst),
            .e_tnew     (e_tnew),
            .m_dst      (m_dst),
            .m_tnew     (m_tnew),
            .w_dst      (w_dst),
            .w_tnew     (w_tnew),
            .addr       (d_rd_addr[i*AW +: AW]),
            .tuse       (d_tuse[i*TW +: TW]),
            .rd_en      (d_rd_en[i]),
            .rf_data    (d_rf_data[i*DW +: DW]),
            .e_data     (e_data),
            .m_data     (m_data),
            .w_data     (w_data),
            .port_stall (port_stall[i]),
            .sel        (fwd_sel[i*2 +: 2]),
            .data       (fwd_data[i*DW +: DW])
        );
    end

    assign mdu_busy = e_mdu | (mdu_cnt != '0);
    assign stall    = d_valid & ((|port_stall) | (d_uses_mdu & mdu_busy));

    // Producer tracking: D enters E unless stalled or empty; M and W always advance
    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst  <= '0;
            e_tnew <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            w_dst  <= '0;
            w_tnew <= '0;
        end else begin
            if (stall || !d_valid) begin
                e_dst  <= '0;
                e_tnew <= '0;
            end else begin
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
            end
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - 1'b1;
            w_dst  <= m_dst;
            w_tnew <= (m_tnew == '0) ? '0 : m_tnew - 1'b1;
        end
    end

    // MDU interlock: flag for the issue cycle, then count down the unit latency
    always_ff @(posedge clk) begin
        if (reset) begin
            e_mdu     <= 1'b0;
            e_mdu_div <= 1'b0;
            mdu_cnt   <= '0;
        end else begin
            e_mdu     <= d_mdu_start & d_valid & ~stall;
            e_mdu_div <= d_mdu_is_div;
            if (e_mdu) begin
                mdu_cnt <= e_mdu_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (mdu_cnt != '0) begin
                mdu_cnt <= mdu_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;
    import hazard_pkg::*;

    localparam int NREAD   = 2;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int TW      = 2;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                d_valid;
    logic [AW-1:0]       d_dst;
    logic [TW-1:0]       d_tnew;
    logic [NREAD*AW-1:0] d_rd_addr;
    logic [NREAD*TW-1:0] d_tuse;
    logic [NREAD-1:0]    d_rd_en;
    logic [NREAD*DW-1:0] d_rf_data;
    logic                d_mdu_start;
    logic                d_mdu_is_div;
    logic                d_uses_mdu;
    logic [DW-1:0]       e_data, m_data, w_data;
    logic                stall;
    logic [NREAD*2-1:0]  fwd_sel;
    logic [NREAD*DW-1:0] fwd_data;
    logic                mdu_busy;

    fwd_hazard_ctrl #(
        .NREAD(NREAD), .AW(AW), .DW(DW), .TW(TW),
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_rd_addr(d_rd_addr), .d_tuse(d_tuse), .d_rd_en(d_rd_en), .d_rf_data(d_rf_data),
        .d_mdu_start(d_mdu_start), .d_mdu_is_div(d_mdu_is_div), .d_uses_mdu(d_uses_mdu),
        .e_data(e_data), .m_data(m_data), .w_data(w_data),
        .stall(stall), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // Reference model: every instruction that left D, with the cycle it left
    typedef struct {
        stage_entry_t ent;
        int           cyc;
    } issue_t;

    issue_t      hist[$];
    int          cyc = 0;
    bit          mdu_on = 0;
    int          mdu_cyc = 0;
    int          mdu_lat = 0;
    int          checks = 0;
    int          errors = 0;
    logic        exp_stall;
    logic        exp_busy;
    logic [1:0]  exp_sel [NREAD];
    logic [DW-1:0] exp_data [NREAD];

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // An instruction that left D at cycle c sits in E/M/W at ages 1/2/3,
    // its result arriving tnew cycles after entering E.
    task automatic model_eval();
        bit port_st = 0;
        int age_mdu = cyc - mdu_cyc;
        exp_busy = mdu_on && (age_mdu >= 1) && (age_mdu <= mdu_lat + 1);
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] addr = d_rd_addr[i*AW +: AW];
            int tuse = int'(d_tuse[i*TW +: TW]);
            bit found = 0;
            exp_sel[i]  = 2'd0;
            exp_data[i] = (addr == 0) ? '0 : d_rf_data[i*DW +: DW];
            if (addr != 0 && d_rd_en[i]) begin
                for (int age = 1; age <= 3; age++) begin
                    foreach (hist[k]) begin
                        if (!found && (cyc - hist[k].cyc) == age && hist[k].ent.dst == addr) begin
                            int rem = int'(hist[k].ent.tnew) - (age - 1);
                            found = 1;
                            if (rem < 0) rem = 0;
                            if (rem == 0) begin
                                exp_sel[i]  = 2'(age);
                                exp_data[i] = (age == 1) ? e_data : (age == 2) ? m_data : w_data;
                            end else if (rem > tuse) begin
                                port_st = 1;
                            end
                        end
                    end
                end
            end
        end
        exp_stall = d_valid && (port_st || (d_uses_mdu && exp_busy));
    endtask

    task automatic check_cycle(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".stall"}, DW'(stall), DW'(exp_stall));
        chk({tag, ".busy"}, DW'(mdu_busy), DW'(exp_busy));
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("%s.sel%0d", tag, i), DW'(fwd_sel[i*2 +: 2]), DW'(exp_sel[i]));
            chk($sformatf("%s.data%0d", tag, i), fwd_data[i*DW +: DW], exp_data[i]);
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            hist.delete();
            mdu_on = 0;
        end else if (d_valid && !exp_stall) begin
            issue_t r;
            r.ent.dst  = d_dst;
            r.ent.tnew = d_tnew;
            r.cyc      = cyc;
            hist.push_back(r);
            if (d_mdu_start) begin
                mdu_on  = 1;
                mdu_cyc = cyc;
                mdu_lat = d_mdu_is_div ? DIV_LAT : MUL_LAT;
            end
        end
        cyc++;
        for (int k = hist.size() - 1; k >= 0; k--)
            if (cyc - hist[k].cyc > 3) hist.delete(k);
        #1;
    endtask

    task automatic step(input string tag);
        check_cycle(tag);
        clock_edge();
    endtask

    task automatic idle();
        reset        = 1'b0;
        d_valid      = 1'b1;
        d_dst        = '0;
        d_tnew       = '0;
        d_rd_addr    = '0;
        d_tuse       = '0;
        d_rd_en      = '0;
        d_rf_data    = {32'h5555, 32'h1234};
        d_mdu_start  = 1'b0;
        d_mdu_is_div = 1'b0;
        d_uses_mdu   = 1'b0;
        e_data       = 32'hAAAA;
        m_data       = 32'hBBBB;
        w_data       = 32'hCCCC;
    endtask

    task automatic issue(input int dst, input int tnew);
        idle();
        d_dst  = AW'(dst);
        d_tnew = TW'(tnew);
    endtask

    task automatic read0(input int addr, input int tuse);
        idle();
        d_rd_addr[0 +: AW] = AW'(addr);
        d_tuse[0 +: TW]    = TW'(tuse);
        d_rd_en[0]         = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step("reset0");
        check_cycle("reset1");
        chk("reset.stall", DW'(stall), '0);
        chk("reset.busy", DW'(mdu_busy), '0);
        clock_edge();

        // No producers: register file value passes through
        read0(8, 0);
        check_cycle("rf_pass");
        chk("rf_pass.sel", DW'(fwd_sel[1:0]), '0);
        chk("rf_pass.data", fwd_data[DW-1:0], 32'h1234);
        clock_edge();

        // E beats W for the same register
        issue(8, 0); step("addu_a");
        issue(5, 0); step("addu_b");
        issue(8, 0); step("addu_c");
        read0(8, 0);
        check_cycle("fwd_e");
        chk("fwd_e.sel", DW'(fwd_sel[1:0]), 32'd1);
        chk("fwd_e.data", fwd_data[DW-1:0], 32'hAAAA);
        clock_edge();

        // Load-use: two stall cycles, then W forwards
        issue(9, 2); step("lw");
        read0(9, 0);
        check_cycle("lu1"); chk("lu1.stall_c", DW'(stall), 32'd1); clock_edge();
        check_cycle("lu2"); chk("lu2.stall_c", DW'(stall), 32'd1); clock_edge();
        check_cycle("lu3");
        chk("lu3.stall_c", DW'(stall), '0);
        chk("lu3.sel", DW'(fwd_sel[1:0]), 32'd3);
        chk("lu3.data", fwd_data[DW-1:0], 32'hCCCC);
        clock_edge();

        // $0 read never stalls and yields zero
        issue(0, 2); step("nop_t2");
        read0(0, 0);
        check_cycle("zero");
        chk("zero.stall_c", DW'(stall), '0);
        chk("zero.data", fwd_data[DW-1:0], '0);
        clock_edge();

        // div then mflo: busy and stalled for 11 cycles, then released
        idle(); d_mdu_start = 1'b1; d_mdu_is_div = 1'b1; d_uses_mdu = 1'b1;
        step("div");
        idle(); d_dst = 5'd3; d_uses_mdu = 1'b1;
        for (int n = 0; n < 11; n++) begin
            check_cycle($sformatf("mflo%0d", n));
            chk($sformatf("mflo%0d.stall_c", n), DW'(stall), 32'd1);
            chk($sformatf("mflo%0d.busy_c", n), DW'(mdu_busy), 32'd1);
            clock_edge();
        end
        check_cycle("mflo_rel");
        chk("mflo_rel.stall_c", DW'(stall), '0);
        chk("mflo_rel.busy_c", DW'(mdu_busy), '0);
        clock_edge();

        // Reset during a load-use stall with the MDU also busy
        idle(); d_mdu_start = 1'b1; d_uses_mdu = 1'b1; step("mul");
        issue(9, 2); step("lw2");
        read0(9, 0);
        reset = 1'b1;
        check_cycle("rst_mid"); chk("rst_mid.stall_c", DW'(stall), 32'd1); clock_edge();
        reset = 1'b0;
        check_cycle("post_rst");
        chk("post_rst.stall_c", DW'(stall), '0);
        chk("post_rst.busy_c", DW'(mdu_busy), '0);
        clock_edge();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            reset        = ($urandom_range(0, 63) == 0);
            d_valid      = ($urandom_range(0, 7) != 0);
            d_dst        = AW'($urandom_range(0, 3));
            d_tnew       = TW'($urandom_range(0, 3));
            for (int i = 0; i < NREAD; i++) begin
                d_rd_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                d_tuse[i*TW +: TW]    = TW'($urandom_range(0, 3));
                d_rd_en[i]            = 1'($urandom_range(0, 1));
                d_rf_data[i*DW +: DW] = $urandom;
            end
            d_mdu_start  = ($urandom_range(0, 15) == 0);
            d_mdu_is_div = 1'($urandom_range(0, 1));
            d_uses_mdu   = d_mdu_start | ($urandom_range(0, 5) == 0);
            e_data       = $urandom;
            m_data       = $urandom;
            w_data       = $urandom;
            step($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and stall controller for the 5-stage MIPS pipeline. It merges bypass muxing with hazard detection and adds multi-cycle MDU interlock.
- Internally tracks destination register and remaining latency (Tnew) of the instructions in E, M and W.
- Per D-stage read port: compares Tuse against Tnew, raises stall, or selects the nearest ready producer's data.
- Sits between the D-stage register-file read and the comparator/ALU operand muxes.

Parameters:
NREAD, 2, number of D-stage register read ports
AW, 5, register address width; address 0 is hard-wired zero
DW, 32, data width
TW, 2, width of Tnew/Tuse fields
MUL_LAT, 5, multiply busy cycles after issue into E
DIV_LAT, 10, divide busy cycles after issue into E

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
d_valid  in  1  D holds a real instruction
d_dst  in  AW  D destination register (0 = none)
d_tnew  in  TW  cycles after entering E until result exists
d_rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
d_tuse  in  NREAD*TW  per-port cycles until operand is needed
d_rd_en  in  NREAD  per-port operand actually used
d_rf_data  in  NREAD*DW  register-file read data
d_mdu_start  in  1  D is mult/div
d_mdu_is_div  in  1  qualifies d_mdu_start
d_uses_mdu  in  1  D reads/writes HI/LO or starts MDU
e_data, m_data, w_data  in  DW each  result buses of E, M, W
stall  out  1  freeze PC/F/D, insert bubble into E
fwd_sel  out  NREAD*2  0=RF, 1=E, 2=M, 3=W
fwd_data  out  NREAD*DW  forwarded operand per port
mdu_busy  out  1  MDU interlock active

Behaviour:
- Reset values:
  - All E/M/W entries: dst=0, tnew=0.
  - MDU counter 0, e_mdu flag 0.
  - Hence stall=0, mdu_busy=0, fwd_sel=0, fwd_data=d_rf_data.
- Stage entries update every clock:
  - E <= (stall or !d_valid) ? {0,0} : {d_dst, d_tnew}.
  - M <= {E.dst, sat_dec(E.tnew)}.
  - W <= {M.dst, sat_dec(M.tnew)}.
  - sat_dec(0)=0. M and W never stall.
- Per port i, combinational:
  - Match at stage S when addr_i != 0, S.dst == addr_i, and d_rd_en[i].
  - Nearest match wins, priority E > M > W; a younger match masks older ones.
  - Ready path: nearest match has tnew == 0 -> fwd_sel = stage code, fwd_data = that stage's data.
  - Stall path: nearest match has tnew > tuse_i -> port stalls.
  - Nearest match with 0 < tnew <= tuse_i: no stall, fwd_sel=0. The operand is re-forwarded from a later stage once ready.
  - No match, or addr_i == 0: fwd_sel=0, fwd_data = (addr_i==0) ? 0 : d_rf_data_i.
  - W-stage forwarding covers same-cycle write/read of the register file.
- MDU interlock:
  - e_mdu flag <= d_mdu_start & d_valid & !stall.
  - Counter loads DIV_LAT or MUL_LAT on the cycle the flag is set (the cycle after issue). Otherwise it decrements to 0 and saturates.
  - mdu_busy = e_mdu | (cnt != 0).
- stall = d_valid & (OR of port stalls | (d_uses_mdu & mdu_busy)).
- Simultaneous events:
  - Stall and an MDU start in D: start is not issued and the counter is unaffected.
  - Reset asserted mid-operation: clears all state on that edge regardless of stall.
- Counter width: clog2(max(MUL_LAT,DIV_LAT)+1).
- All outputs except registered state are combinational from current inputs and state; latency 0.

Decomposition:
- Shared package (hazard_pkg):
  - Stage select constants SEL_RF/SEL_E/SEL_M/SEL_W.
  - Tnew/Tuse width.
  - Latency defaults.
  - Stage-entry struct {dst, tnew}.
- Sub-module fwd_port_sel, instantiated NREAD times via generate:
  - Inputs: three stage entries, one address/tuse/rd_en/rf_data, three data buses.
  - Outputs: port_stall, sel, data.

Test Plan:
- Reset, then read $8 with no producers -> stall=0, fwd_sel=0, fwd_data=d_rf_data (0x1234).
- addu $8 (tnew=0) in E, D reads $8 with tuse=0 -> fwd_sel=1, fwd_data=e_data=0xAAAA. Same address also in W -> still sel=1 (priority).
- lw $9 (tnew=2) issued, next instr beq reads $9 with tuse=0:
  - stall=1 for 2 cycles, E bubbles.
  - Third cycle: fwd_sel=3 (W), fwd_data=w_data.
- D reads $0 while E.dst=0 with tnew=2 -> stall=0, fwd_data=0.
- div issued, then mflo at D:
  - mdu_busy=1 and stall=1 for 11 cycles after issue (flag + 10).
  - Released on the cycle the counter reads 0.
- Reset asserted during lw stall -> next cycle stall=0, entries cleared, counter 0.
